// File: rtl/bus_pkg.sv
// Shared definitions for the bus master front end: control codes, bus width
// defaults and the master FSM state encoding.
package bus_pkg;

  localparam int BUS_WIDTH_DEF  = 32;
  localparam int CTRL_WIDTH_DEF = 8;

  localparam logic [7:0] CTRL_IDLE  = 8'h00;
  localparam logic [7:0] CTRL_READ  = 8'h01;
  localparam logic [7:0] CTRL_WRITE = 8'h02;
  localparam logic [7:0] CTRL_WDATA = 8'h03;
  localparam logic [7:0] CTRL_RDATA = 8'h04;
  localparam logic [7:0] CTRL_WACK  = 8'h05;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_ADDR,
    ST_DATA,
    ST_WAIT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/bus_master_port.sv
// Single-outstanding bus master: CPU load/store -> arbitrated bus transaction.
// Every output is a flop loaded from the next-state decode, so outputs track the state.
module bus_master_port
  import bus_pkg::*;
#(
  parameter int BUS_WIDTH  = BUS_WIDTH_DEF,
  parameter int CTRL_WIDTH = CTRL_WIDTH_DEF,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_valid,
  input  logic                  cpu_write,
  input  logic [BUS_WIDTH-1:0]  cpu_addr,
  input  logic [BUS_WIDTH-1:0]  cpu_wdata,
  output logic                  cpu_ready,
  output logic                  cpu_done,
  output logic [BUS_WIDTH-1:0]  cpu_rdata,
  output logic                  cpu_err,
  output logic                  req,
  input  logic                  ack,
  input  logic [BUS_WIDTH-1:0]  bus_in,
  input  logic [CTRL_WIDTH-1:0] ctrl_in,
  input  logic                  ready_in,
  output logic [BUS_WIDTH-1:0]  bus_out,
  output logic [CTRL_WIDTH-1:0] ctrl_out
);

  // Width floor of 1 keeps the counter legal when the timeout is disabled.
  localparam int              CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]   TO_VAL  = CW'(TIMEOUT);
  localparam logic [CW-1:0]   CNT_MAX = '1;

  state_e                 state_q, state_d;
  logic                   wr_q;
  logic [BUS_WIDTH-1:0]   addr_q, wdata_q;
  logic [CW-1:0]          cnt_q;
  logic                   err_d;
  logic [BUS_WIDTH-1:0]   bus_d;
  logic [CTRL_WIDTH-1:0]  ctrl_d;
  logic                   accept, rd_hit, wr_hit, to_hit;

  // cpu_ready is a flop, so gating on it holds off acceptance for the cycle
  // right after reset even though the state is already IDLE.
  assign accept = cpu_ready && cpu_valid;
  assign rd_hit = !wr_q && (ctrl_in == CTRL_WIDTH'(CTRL_RDATA));
  assign wr_hit =  wr_q && (ctrl_in == CTRL_WIDTH'(CTRL_WACK));
  assign to_hit = (TIMEOUT != 0) && (cnt_q == TO_VAL);

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_REQ;
      ST_REQ:  if (ack && ready_in) state_d = ST_ADDR;
      ST_ADDR: begin
        if (!ack) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else begin
          state_d = wr_q ? ST_DATA : ST_WAIT;
        end
      end
      ST_DATA: begin
        if (!ack) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Grant loss beats completion, completion beats timeout.
        if (!ack) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else if (rd_hit || wr_hit) begin
          state_d = ST_DONE;
        end else if (to_hit) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus_d  = '0;
    ctrl_d = CTRL_WIDTH'(CTRL_IDLE);
    case (state_d)
      ST_ADDR: begin
        bus_d  = addr_q;
        ctrl_d = wr_q ? CTRL_WIDTH'(CTRL_WRITE) : CTRL_WIDTH'(CTRL_READ);
      end
      ST_DATA: begin
        bus_d  = wdata_q;
        ctrl_d = CTRL_WIDTH'(CTRL_WDATA);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      cpu_ready <= 1'b0;
      cpu_done  <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= '0;
      req       <= 1'b0;
      bus_out   <= '0;
      ctrl_out  <= CTRL_WIDTH'(CTRL_IDLE);
    end else begin
      state_q <= state_d;
      if (accept) begin
        wr_q    <= cpu_write;
        addr_q  <= cpu_addr;
        wdata_q <= cpu_wdata;
      end
      // Cleared everywhere outside WAIT, so it reads zero on the first WAIT cycle.
      if (state_q != ST_WAIT)   cnt_q <= '0;
      else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
      if (state_q == ST_WAIT && ack && rd_hit) cpu_rdata <= bus_in;
      cpu_ready <= (state_d == ST_IDLE);
      cpu_done  <= (state_d == ST_DONE);
      cpu_err   <= (state_d == ST_DONE) && err_d;
      req       <= (state_d inside {ST_REQ, ST_ADDR, ST_DATA, ST_WAIT});
      bus_out   <= bus_d;
      ctrl_out  <= ctrl_d;
    end
  end

endmodule

// File: tb/tb_bus_master_port.sv
// Directed bench for bus_master_port: table of load/store transactions plus
// hand sequences for grant delay, grant loss and mid-transaction reset.
module tb_bus_master_port;
  import bus_pkg::*;

  localparam int BW = 32;
  localparam int CWD = 8;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           cpu_valid = 1'b0, cpu_write = 1'b0;
  logic [BW-1:0]  cpu_addr = '0, cpu_wdata = '0;
  logic           cpu_ready, cpu_done, cpu_err, req;
  logic [BW-1:0]  cpu_rdata, bus_out;
  logic [CWD-1:0] ctrl_out;
  logic           ack = 1'b1, ready_in = 1'b1;
  logic [BW-1:0]  bus_in = '0;
  logic [CWD-1:0] ctrl_in = '0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;     // WAIT cycle index of the response; -1 = never
    logic [7:0]  noise;     // code driven in WAIT cycle 0 that must be ignored
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];

  bus_master_port #(.BUS_WIDTH(BW), .CTRL_WIDTH(CWD), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .cpu_valid(cpu_valid), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .req(req), .ack(ack), .bus_in(bus_in), .ctrl_in(ctrl_in), .ready_in(ready_in),
    .bus_out(bus_out), .ctrl_out(ctrl_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int n;
    chk({tag, "_ready"}, cpu_ready, 1);
    cpu_valid = 1'b1; cpu_write = v.wr; cpu_addr = v.addr; cpu_wdata = v.wdata;
    step();
    cpu_valid = 1'b0;
    chk({tag, "_req"}, req, 1);
    chk({tag, "_req_ctrl"}, ctrl_out, 0);
    chk({tag, "_req_notready"}, cpu_ready, 0);
    step();
    chk({tag, "_addr_ctrl"}, ctrl_out, v.wr ? 32'h02 : 32'h01);
    chk({tag, "_addr_bus"}, bus_out, v.addr);
    if (v.wr) begin
      step();
      chk({tag, "_wdata_ctrl"}, ctrl_out, 32'h03);
      chk({tag, "_wdata_bus"}, bus_out, v.wdata);
    end
    step();
    chk({tag, "_wait_ctrl"}, ctrl_out, 0);
    chk({tag, "_wait_bus"}, bus_out, 0);
    if (v.delay >= 0) begin
      for (int i = 0; i < v.delay; i++) begin
        ctrl_in = (i == 0) ? v.noise : 8'h00;
        bus_in  = 32'hBAD0_0000 + i;
        step();
        chk({tag, "_early_done"}, cpu_done, 0);
      end
      ctrl_in = v.wr ? 8'h05 : 8'h04;
      bus_in  = v.rdata;
      step();
      ctrl_in = 8'h00;
      bus_in  = '0;
    end else begin
      n = 0;
      while (cpu_done !== 1'b1 && n < 40) begin
        step();
        n++;
      end
      chk({tag, "_timeout_cycles"}, n, 9);
    end
    chk({tag, "_done"}, cpu_done, 1);
    chk({tag, "_err"}, cpu_err, v.exp_err);
    chk({tag, "_rdata"}, cpu_rdata, v.exp_rdata);
    chk({tag, "_done_req"}, req, 0);
    step();
    chk({tag, "_done_pulse"}, cpu_done, 0);
    chk({tag, "_idle_ready"}, cpu_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vecs[0] = '{1'b0, 32'h0000_0010, 32'h0,          32'hDEAD_BEEF, 2,  8'h00, 1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 32'h0000_0020, 32'h1234_5678,  32'h0,         0,  8'h00, 1'b0, 32'hDEAD_BEEF};
    vecs[2] = '{1'b0, 32'hFFFF_FFFC, 32'h0,          32'hA5A5_5A5A, 0,  8'h00, 1'b0, 32'hA5A5_5A5A};
    vecs[3] = '{1'b1, 32'h0000_0004, 32'hFFFF_FFFF,  32'h0,         3,  8'h04, 1'b0, 32'hA5A5_5A5A};
    vecs[4] = '{1'b0, 32'h0000_0100, 32'h0,          32'h0000_0001, 5,  8'h05, 1'b0, 32'h0000_0001};
    vecs[5] = '{1'b0, 32'h0000_0200, 32'h0,          32'h1357_9BDF, 8,  8'h07, 1'b0, 32'h1357_9BDF};
    vecs[6] = '{1'b0, 32'h0000_0300, 32'h0,          32'h0,         -1, 8'h00, 1'b1, 32'h1357_9BDF};
    vecs[7] = '{1'b1, 32'h0000_0400, 32'hCAFE_0000,  32'h0,         -1, 8'h00, 1'b1, 32'h1357_9BDF};

    // Reset state
    step(); step();
    chk("rst_req", req, 0);
    chk("rst_ready", cpu_ready, 0);
    chk("rst_done", cpu_done, 0);
    chk("rst_err", cpu_err, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_bus", bus_out, 0);
    chk("rst_ctrl", ctrl_out, 0);
    reset = 1'b0;
    step();
    chk("rst_release_ready", cpu_ready, 1);

    for (int k = 0; k < 8; k++) run_vec(vecs[k], $sformatf("v%0d", k));

    // Grant delay: ack low 10 cycles, then ready_in low 2 cycles
    ack = 1'b0;
    cpu_valid = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h0000_0080;
    step();
    cpu_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("gd_req", req, 1);
      chk("gd_ctrl", ctrl_out, 0);
      chk("gd_bus", bus_out, 0);
      step();
    end
    ack = 1'b1; ready_in = 1'b0;
    step(); step();
    chk("gd_notready_ctrl", ctrl_out, 0);
    ready_in = 1'b1;
    step();
    chk("gd_addr_ctrl", ctrl_out, 32'h01);
    chk("gd_addr_bus", bus_out, 32'h0000_0080);
    step();
    ctrl_in = 8'h04; bus_in = 32'h0BAD_F00D;
    step();
    ctrl_in = 8'h00; bus_in = '0;
    chk("gd_done", cpu_done, 1);
    chk("gd_rdata", cpu_rdata, 32'h0BAD_F00D);
    step();

    // Grant loss during WAIT
    cpu_valid = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h0000_0040;
    step();
    cpu_valid = 1'b0;
    step(); step();
    ack = 1'b0;
    step();
    chk("gl_done", cpu_done, 1);
    chk("gl_err", cpu_err, 1);
    chk("gl_req", req, 0);
    chk("gl_rdata", cpu_rdata, 32'h0BAD_F00D);
    ack = 1'b1;
    step();
    chk("gl_ready", cpu_ready, 1);
    v = '{1'b1, 32'h0000_0044, 32'h0F0F_0F0F, 32'h0, 1, 8'h00, 1'b0, 32'h0BAD_F00D};
    run_vec(v, "gl_next");

    // Reset mid-transaction
    cpu_valid = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h0000_0050;
    step();
    cpu_valid = 1'b0;
    step(); step(); step();
    chk("mr_in_wait", req, 1);
    reset = 1'b1;
    step();
    chk("mr_req", req, 0);
    chk("mr_ctrl", ctrl_out, 0);
    chk("mr_done", cpu_done, 0);
    chk("mr_rdata", cpu_rdata, 0);
    reset = 1'b0;
    step();
    chk("mr_ready", cpu_ready, 1);
    chk("mr_done_after", cpu_done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_master_port.md
# bus_master_port

Single-outstanding bus master front end that turns a simple CPU-side load/store request into a transaction on the shared 32-bit data / 8-bit control bus. It sits upstream of the SRAM controller: it requests the bus from the arbiter, drives address, opcode and write data, then waits for the slave's completion code. Read data or an error is returned to the requester.

## Interface
- `BUS_WIDTH`, 32: width of the data bus, address and data.
- `CTRL_WIDTH`, 8: width of the control bus.
- `TIMEOUT`, 1024: maximum number of cycles spent in WAIT before the transaction is abandoned. A value of 0 disables the timeout.
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `cpu_valid`  in  1  request present.
- `cpu_write`  in  1  1 = store, 0 = load.
- `cpu_addr`  in  BUS_WIDTH  byte address, passed through unmodified.
- `cpu_wdata`  in  BUS_WIDTH  store data.
- `cpu_ready`  out  1  block can accept a request this cycle.
- `cpu_done`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  BUS_WIDTH  load data; holds its value until the next load completes.
- `cpu_err`  out  1  qualifies `cpu_done`: the transaction timed out or its grant was lost.
- `req`  out  1  bus request to the arbiter.
- `ack`  in  1  bus grant from the arbiter.
- `bus_in`  in  BUS_WIDTH  arbitrated bus data.
- `ctrl_in`  in  CTRL_WIDTH  arbitrated control code.
- `ready_in`  in  1  slave idle / ready indication.
- `bus_out`  out  BUS_WIDTH  data driven toward the arbiter.
- `ctrl_out`  out  CTRL_WIDTH  control code driven toward the arbiter.

## Operation
- **Control codes:** IDLE=8'h00, READ=8'h01, WRITE=8'h02, WDATA=8'h03, RDATA=8'h04, WACK=8'h05. All other codes are ignored.
- **IDLE:** `cpu_ready`=1. When `cpu_valid` is high, the block latches write, addr and wdata, then moves to REQ.
- **REQ:** `req`=1. The block stays in REQ until `ack` and `ready_in` are both high in the same cycle, then moves to ADDR.
- **ADDR:** one cycle. `bus_out`=addr and `ctrl_out`=READ or WRITE. A store moves to DATA; a load moves to WAIT.
- **DATA:** one cycle. `bus_out`=wdata and `ctrl_out`=WDATA. Then moves to WAIT.
- **WAIT:** `bus_out`=0 and `ctrl_out`=IDLE.
  - A load completes on `ctrl_in`==RDATA; `cpu_rdata` captures `bus_in` on that edge.
  - A store completes on `ctrl_in`==WACK.
  - On completion the block moves to DONE with err=0.
- **DONE:** one cycle. `cpu_done`=1, `req`=0, then back to IDLE.
- **Grant loss:** `req` stays high in ADDR, DATA and WAIT. If `ack` is sampled low in any of these states, the block goes to DONE with `cpu_err`=1 and `cpu_rdata` unchanged.
- **Timeout:** the counter clears on entry to WAIT and increments once per WAIT cycle. When the count reaches TIMEOUT, the block goes to DONE with `cpu_err`=1.
- **Simultaneous events:** completion takes priority over timeout in the same cycle. Grant loss takes priority over both.
- **Signals outside their active states:** `ready_in` and `ctrl_in` are ignored outside REQ and WAIT.
- **Reset:** outputs go to `req`=0, `cpu_ready`=0, `cpu_done`=0, `cpu_err`=0, `cpu_rdata`=0, `bus_out`=0, `ctrl_out`=IDLE, and the state goes to IDLE. `cpu_ready` rises on the first cycle after `reset` deasserts. A reset mid-transaction produces no `cpu_done`, and `req` is low on the first cycle after `reset` is sampled.

## Timing
- All outputs are registered; nothing is combinational from input to output.
- **Minimum load, `ack` and `ready_in` already high:**
  - accept at edge 0;
  - REQ at cycle 1;
  - ADDR at cycle 2;
  - WAIT from cycle 3;
  - RDATA in cycle N moves the block to DONE at N+1, pulsing `cpu_done` that cycle;
  - IDLE, with `cpu_ready`=1, at N+2.
- A minimum store adds one cycle for DATA.
- Back-to-back transactions: a new request can be accepted in the IDLE cycle that follows DONE. The gap between `cpu_done` pulses is at least 5 cycles.
- The timeout counter is `$clog2(TIMEOUT+1)` bits wide and saturates; it never wraps.

## Structure
- Shared package `bus_pkg` holds:
  - the control-code localparams;
  - the `BUS_WIDTH` and `CTRL_WIDTH` defaults;
  - the state enum (IDLE, REQ, ADDR, DATA, WAIT, DONE).
- No sub-module; a single FSM plus the timeout counter.

## Test plan
- **Load:** request a load of addr 32'h0000_0010; the slave model answers RDATA with 32'hDEAD_BEEF three cycles after ADDR. Required: `cpu_done`=1, `cpu_err`=0, `cpu_rdata`=32'hDEAD_BEEF, one ADDR cycle observed with `ctrl_out`=8'h01.
- **Store:** request a store of 32'h1234_5678 to addr 32'h20. Required: ADDR cycle with `ctrl_out`=8'h02, next cycle WDATA with `bus_out`=32'h1234_5678, `cpu_done` one cycle after WACK.
- **Grant delay:** hold `ack`=0 for 10 cycles. Required: `req` stays high, `bus_out`/`ctrl_out` stay IDLE, and ADDR appears one cycle after `ack` rises.
- **Timeout:** with TIMEOUT=8, the slave never responds. Required: `cpu_done`=1 with `cpu_err`=1 exactly 9 cycles after entering WAIT, and `cpu_rdata` unchanged.
- **Grant loss:** drop `ack` during WAIT. Required: `cpu_err`=1 pulse, `req` low the cycle after, and a new request is accepted.
- **Reset mid-transaction:** assert `reset` during WAIT. Required: no `cpu_done`, `req`=0 and `ctrl_out`=0 after the next edge, and `cpu_ready`=1 the cycle after `reset` drops.
